// File: rtl/median9_sort_scheduler.sv
// Median-of-row-medians over a 9x9 window. One 9-input sorter is reused for nine row passes and one final pass.
// Optional macro MEDIAN9_SCHED_MINMAX_EN adds win_min/win_max outputs.

module median9_sorter9 #(
  parameter int DW = 8
) (
  input  logic [8:0][DW-1:0] in_data,
`ifdef MEDIAN9_SCHED_MINMAX_EN
  output logic [DW-1:0]      min_o,
  output logic [DW-1:0]      max_o,
`endif
  output logic [DW-1:0]      mid_o
);

  logic [8:0][DW-1:0] s;
  logic [DW-1:0]      t;

  // Bubble network: every comparator is a plain compare-and-swap, so ties need no special handling.
  always_comb begin
    s = in_data;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t      = s[j];
          s[j]   = s[j+1];
          s[j+1] = t;
        end
      end
    end
  end

  assign mid_o = s[4];
`ifdef MEDIAN9_SCHED_MINMAX_EN
  assign min_o = s[0];
  assign max_o = s[8];
`endif

endmodule

module median9_sort_scheduler #(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [81*DW-1:0] window,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    median,
`ifdef MEDIAN9_SCHED_MINMAX_EN
  output logic [DW-1:0]    win_min,
  output logic [DW-1:0]    win_max,
`endif
  output logic             busy,
  output logic [3:0]       pass_idx
);

  typedef enum logic [1:0] {IDLE, ROW, FINAL, DONE} state_t;

  state_t state_q, state_d;

  logic [8:0][8:0][DW-1:0] win_q, win_d;
  logic [8:0][DW-1:0]      mid_q, mid_d;
  logic [3:0]              pass_q, pass_d;
  logic [DW-1:0]           median_q, median_d;
  logic                    out_valid_q, out_valid_d;

  logic [8:0][DW-1:0]      sort_in;
  logic [DW-1:0]           sort_mid;

`ifdef MEDIAN9_SCHED_MINMAX_EN
  logic [DW-1:0]           sort_min, sort_max;
  logic [DW-1:0]           win_min_q, win_min_d;
  logic [DW-1:0]           win_max_q, win_max_d;
`endif

  always_comb begin
    sort_in = mid_q;
    if (state_q == ROW) begin
      sort_in = win_q[pass_q];
    end
  end

  median9_sorter9 #(.DW(DW)) u_sorter (
    .in_data (sort_in),
`ifdef MEDIAN9_SCHED_MINMAX_EN
    .min_o   (sort_min),
    .max_o   (sort_max),
`endif
    .mid_o   (sort_mid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = ROW;
      ROW:     if (pass_q == 4'd8)  state_d = FINAL;
      FINAL:                        state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == ROW) || (state_q == FINAL);
  end

  // The window is captured only on acceptance, so later changes on the port cannot reach the result.
  always_comb begin
    win_d       = win_q;
    mid_d       = mid_q;
    pass_d      = pass_q;
    median_d    = median_q;
    out_valid_d = out_valid_q;
`ifdef MEDIAN9_SCHED_MINMAX_EN
    win_min_d   = win_min_q;
    win_max_d   = win_max_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          win_d  = window;
          pass_d = 4'd0;
        end
      end
      ROW: begin
        mid_d[pass_q] = sort_mid;
        pass_d        = pass_q + 4'd1;
`ifdef MEDIAN9_SCHED_MINMAX_EN
        if (pass_q == 4'd0) begin
          win_min_d = sort_min;
          win_max_d = sort_max;
        end else begin
          if (sort_min < win_min_q) win_min_d = sort_min;
          if (sort_max > win_max_q) win_max_d = sort_max;
        end
`endif
      end
      FINAL: begin
        median_d    = sort_mid;
        out_valid_d = 1'b1;
        pass_d      = 4'd0;
      end
      DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      mid_q       <= '0;
      pass_q      <= '0;
      median_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef MEDIAN9_SCHED_MINMAX_EN
      win_min_q   <= '0;
      win_max_q   <= '0;
`endif
    end else begin
      win_q       <= win_d;
      mid_q       <= mid_d;
      pass_q      <= pass_d;
      median_q    <= median_d;
      out_valid_q <= out_valid_d;
`ifdef MEDIAN9_SCHED_MINMAX_EN
      win_min_q   <= win_min_d;
      win_max_q   <= win_max_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign median    = median_q;
  assign pass_idx  = pass_q;
`ifdef MEDIAN9_SCHED_MINMAX_EN
  assign win_min   = win_min_q;
  assign win_max   = win_max_q;
`endif

endmodule

// File: tb/tb_median9_sort_scheduler.sv
// Directed self-checking bench for median9_sort_scheduler; inputs driven and outputs sampled on the falling edge.
// Honours MEDIAN9_SCHED_MINMAX_EN when the design is built with it.

module tb_median9_sort_scheduler;

  localparam int DW = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [81*DW-1:0] window;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    median;
  logic             busy;
  logic [3:0]       pass_idx;
`ifdef MEDIAN9_SCHED_MINMAX_EN
  logic [DW-1:0]    win_min;
  logic [DW-1:0]    win_max;
`endif

  int vectors;
  int miscompares;
  int edges;

  logic [81*DW-1:0] win_seven, win_rows, win_mix, win_three, win_200;
  int row_a [9] = '{10, 55, 23, 18, 92, 44, 67, 31, 76};
  int row_b [9] = '{90, 10, 70, 50, 30, 80, 20, 60, 40};

  median9_sort_scheduler #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .window    (window),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .median    (median),
`ifdef MEDIAN9_SCHED_MINMAX_EN
    .win_min   (win_min),
    .win_max   (win_max),
`endif
    .busy      (busy),
    .pass_idx  (pass_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a window at a falling edge and hold it until the rising edge where it is taken.
  task automatic applyStimulus(input logic [81*DW-1:0] w);
    int guard;
    window   = w;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    window      = '0;

    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        win_seven[DW*(9*r+c) +: DW] = DW'(7);
        win_rows [DW*(9*r+c) +: DW] = DW'(10*r);
        win_mix  [DW*(9*r+c) +: DW] = (r < 5) ? DW'(row_a[c]) : DW'(row_b[c]);
        win_three[DW*(9*r+c) +: DW] = DW'(3);
        win_200  [DW*(9*r+c) +: DW] = DW'(200);
      end
    end

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_median", 32'(median), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pass_idx", 32'(pass_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All pixels equal
    applyStimulus(win_seven);
    waitOutput(edges);
    checkOutput("flat_latency", 32'(edges), 32'd10);
    checkOutput("flat_median", 32'(median), 32'd7);
    @(negedge clk);
    checkOutput("flat_out_valid_clr", 32'(out_valid), 32'd0);
    checkOutput("flat_busy_low", 32'(busy), 32'd0);
    checkOutput("flat_in_ready", 32'(in_ready), 32'd1);

    // Row r = 10*r, pass index walks 0..9
    applyStimulus(win_rows);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("rows_pass_%0d", k), 32'(pass_idx), 32'(k));
      checkOutput($sformatf("rows_busy_%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("rows_out_valid", 32'(out_valid), 32'd1);
    checkOutput("rows_median", 32'(median), 32'd40);
    checkOutput("rows_pass_done", 32'(pass_idx), 32'd0);
`ifdef MEDIAN9_SCHED_MINMAX_EN
    checkOutput("rows_win_min", 32'(win_min), 32'd0);
    checkOutput("rows_win_max", 32'(win_max), 32'd80);
`endif
    @(negedge clk);

    // Mixed rows with back-pressure and a competing window during the hold
    out_ready = 1'b0;
    applyStimulus(win_mix);
    waitOutput(edges);
    checkOutput("mix_latency", 32'(edges), 32'd10);
    window   = win_three;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_out_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold_median_%0d", i), 32'(median), 32'd44);
      checkOutput($sformatf("hold_in_ready_%0d", i), 32'(in_ready), 32'd0);
`ifdef MEDIAN9_SCHED_MINMAX_EN
      checkOutput($sformatf("hold_win_min_%0d", i), 32'(win_min), 32'd10);
      checkOutput($sformatf("hold_win_max_%0d", i), 32'(win_max), 32'd92);
`endif
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hs_out_valid_clr", 32'(out_valid), 32'd0);
    checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
    checkOutput("hs_busy", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("next_accept_busy", 32'(busy), 32'd1);
    checkOutput("next_accept_in_ready", 32'(in_ready), 32'd0);
    waitOutput(edges);
    checkOutput("next_latency", 32'(edges), 32'd10);
    checkOutput("next_median", 32'(median), 32'd3);
    @(negedge clk);

    // Reset in the middle of pass 4
    applyStimulus(win_rows);
    repeat (4) @(negedge clk);
    checkOutput("abort_pass_before", 32'(pass_idx), 32'd4);
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_median", 32'(median), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_pass_idx", 32'(pass_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(win_200);
    waitOutput(edges);
    checkOutput("post_abort_latency", 32'(edges), 32'd10);
    checkOutput("post_abort_median", 32'(median), 32'd200);
    @(negedge clk);

    // Window scrambled every cycle after acceptance
    applyStimulus(win_mix);
    edges = 0;
    while (!out_valid && edges < 30) begin
      for (int p = 0; p < 81; p++) begin
        window[DW*p +: DW] = DW'($urandom_range(0, 255));
      end
      @(negedge clk);
      edges++;
    end
    checkOutput("scramble_latency", 32'(edges), 32'd10);
    checkOutput("scramble_median", 32'(median), 32'd44);
`ifdef MEDIAN9_SCHED_MINMAX_EN
    checkOutput("scramble_win_min", 32'(win_min), 32'd10);
    checkOutput("scramble_win_max", 32'(win_max), 32'd92);
`endif
    @(negedge clk);
    checkOutput("final_idle", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
